// File: rtl/store_buffer_pkg.sv
// -----------------------------------------------------------------------------
// store_buffer_pkg
//   Shared types and default sizing for the posted-write store buffer.
//
//   sb_entry_t : one buffered store, {word address, data}. The two low byte
//                address bits are dropped because every store is word aligned.
//   SB_DEPTH / SB_AW / SB_DW : default buffer depth, address and data widths.
//
//   sb_entry_t is sized from SB_AW / SB_DW, so an instance that overrides
//   AW or DW must use matching package values.
// -----------------------------------------------------------------------------
package store_buffer_pkg;

  localparam int SB_DEPTH = 4;
  localparam int SB_AW    = 32;
  localparam int SB_DW    = 32;

  typedef struct packed {
    logic [SB_AW-3:0] addr;
    logic [SB_DW-1:0] data;
  } sb_entry_t;

  // Word address of a byte address (drops the two byte-offset bits).
  function automatic logic [SB_AW-3:0] sb_word_addr(input logic [SB_AW-1:0] byte_addr);
    return byte_addr[SB_AW-1:2];
  endfunction

endpackage

// File: rtl/store_buffer_if.sv
// -----------------------------------------------------------------------------
// store_buffer_if
//   Memory-side bus of the store buffer: one posted-write request channel and
//   one combinational read port.
//
//   Write channel handshake (req/ack):
//     mem_req is high while the buffer holds at least one store. mem_waddr and
//     mem_wdata carry the oldest store and stay stable while mem_req is high
//     and mem_ack is low. A write transfers on a posedge where mem_req and
//     mem_ack are both high; the buffer then presents the next store (or drops
//     mem_req). mem_ack while mem_req is low means nothing. The only way a
//     request disappears without an ack is reset, and the memory must treat
//     such an abandoned request as never issued.
//
//   Read port:
//     mem_raddr mirrors the core's load address combinationally and mem_rdata
//     returns the memory word in the same cycle.
//
//   Modports:
//     master : store buffer side (drives req/waddr/wdata/raddr)
//     slave  : data memory side  (drives ack/rdata)
// -----------------------------------------------------------------------------
interface store_buffer_if #(
  parameter int AW = 32,
  parameter int DW = 32
) ();

  logic          mem_req;
  logic [AW-1:0] mem_waddr;
  logic [DW-1:0] mem_wdata;
  logic          mem_ack;
  logic [AW-1:0] mem_raddr;
  logic [DW-1:0] mem_rdata;

  modport master (
    output mem_req,
    output mem_waddr,
    output mem_wdata,
    output mem_raddr,
    input  mem_ack,
    input  mem_rdata
  );

  modport slave (
    input  mem_req,
    input  mem_waddr,
    input  mem_wdata,
    input  mem_raddr,
    output mem_ack,
    output mem_rdata
  );

endinterface

// File: rtl/store_buffer_fwd_match.sv
// -----------------------------------------------------------------------------
// sb_fwd_match
//   Combinational store-to-load forwarding search. Finds the youngest valid
//   buffered store whose word address equals the load's word address.
//
//   Ports:
//     entries   in  buffered stores, indexed by slot
//     valid     in  per-slot valid mask (slot holds a not-yet-drained store)
//     tail      in  next slot to be written; tail-1 is the youngest store
//     load_addr in  word address of the current load
//     hit       out some valid entry matches
//     hit_data  out data of the youngest matching entry (0 when no hit)
// -----------------------------------------------------------------------------
module sb_fwd_match
  import store_buffer_pkg::*;
#(
  parameter int DEPTH = SB_DEPTH,
  parameter int PW    = $clog2(DEPTH)
) (
  input  sb_entry_t         entries [DEPTH],
  input  logic [DEPTH-1:0]  valid,
  input  logic [PW-1:0]     tail,
  input  logic [SB_AW-3:0]  load_addr,
  output logic              hit,
  output logic [SB_DW-1:0]  hit_data
);

  logic [PW-1:0] idx;

  // Walk from the oldest possible slot (tail-DEPTH == tail) to the youngest
  // (tail-1). Later matches overwrite earlier ones, so the youngest wins.
  always_comb begin
    hit      = 1'b0;
    hit_data = '0;
    idx      = '0;
    for (int k = DEPTH; k >= 1; k--) begin
      idx = tail - PW'(k);
      if (valid[idx] && (entries[idx].addr == load_addr)) begin
        hit      = 1'b1;
        hit_data = entries[idx].data;
      end
    end
  end

endmodule

// File: rtl/store_buffer.sv
// -----------------------------------------------------------------------------
// store_buffer
//   Posted-write buffer between a single-cycle core's data port and a slower
//   data memory. Core stores land in an in-order circular FIFO in one cycle and
//   drain to memory over the req/ack channel of store_buffer_if. Loads read
//   memory combinationally; the youngest matching buffered store overrides the
//   memory data so program order is preserved. stall is raised only when a
//   store meets a full buffer.
//
//   Ports:
//     clk        in  clock
//     reset      in  asynchronous, active-high; discards buffered stores
//     cpu_we     in  core store strobe
//     cpu_addr   in  core byte address (bits [1:0] ignored for matching/storing)
//     cpu_wdata  in  core store data
//     cpu_rdata  out load data to core (forwarded or memory)
//     stall      out core must hold PC and all state this cycle
//     empty      out no pending stores
//     mem        master side of store_buffer_if (write req/ack + read port)
// -----------------------------------------------------------------------------
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int DEPTH = SB_DEPTH,
  parameter int AW    = SB_AW,
  parameter int DW    = SB_DW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  output logic          stall,
  output logic          empty,
  store_buffer_if.master mem
);

  localparam int PW = $clog2(DEPTH);

  // ---------------------------------------------------------------------------
  // FIFO state
  // ---------------------------------------------------------------------------
  sb_entry_t        entries [DEPTH];
  logic [PW-1:0]    head;
  logic [PW-1:0]    tail;
  logic [PW:0]      count;

  logic             full;
  logic             is_empty;
  logic             push;
  logic             pop;
  logic [DEPTH-1:0] valid;

  assign full     = (count == (PW+1)'(DEPTH));
  assign is_empty = (count == '0);

  // Stall and push both look only at the registered count: an ack arriving in
  // the same cycle frees a slot for the next cycle, not this one.
  assign push  = cpu_we & ~full;
  assign pop   = ~is_empty & mem.mem_ack;
  assign stall = cpu_we & full;
  assign empty = is_empty;

  // ---------------------------------------------------------------------------
  // Pointers and occupancy
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Entry payload needs no reset: a slot is only observed while it is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      entries[tail].addr <= sb_word_addr(cpu_addr);
      entries[tail].data <= cpu_wdata;
    end
  end

  // ---------------------------------------------------------------------------
  // Valid mask: slot i holds a pending store when its distance from head
  // (modulo DEPTH) is below count. The head slot stays valid through the cycle
  // in which it is acked, so it still forwards.
  // ---------------------------------------------------------------------------
  logic [PW-1:0] slot_off [DEPTH];

  always_comb begin
    valid = '0;
    for (int i = 0; i < DEPTH; i++) begin
      slot_off[i] = PW'(i) - head;
      valid[i]    = ({1'b0, slot_off[i]} < count);
    end
  end

  // ---------------------------------------------------------------------------
  // Memory write channel: head entry, held until acked
  // ---------------------------------------------------------------------------
  assign mem.mem_req   = ~is_empty;
  assign mem.mem_waddr = {entries[head].addr, 2'b00};
  assign mem.mem_wdata = entries[head].data;

  // ---------------------------------------------------------------------------
  // Load path: combinational, forwarding independent of cpu_we
  // ---------------------------------------------------------------------------
  logic          fwd_hit;
  logic [DW-1:0] fwd_data;

  sb_fwd_match #(
    .DEPTH (DEPTH),
    .PW    (PW)
  ) u_fwd_match (
    .entries   (entries),
    .valid     (valid),
    .tail      (tail),
    .load_addr (sb_word_addr(cpu_addr)),
    .hit       (fwd_hit),
    .hit_data  (fwd_data)
  );

  assign mem.mem_raddr = cpu_addr;
  assign cpu_rdata     = fwd_hit ? fwd_data : mem.mem_rdata;

endmodule

// File: tb/tb_store_buffer.sv
// -----------------------------------------------------------------------------
// tb_store_buffer
//   Directed and randomized bench for store_buffer. A queue of pending
//   {word address, data} stores serves as the reference: stores push at the
//   back, acks pop the front, loads search the queue from youngest to oldest.
// -----------------------------------------------------------------------------
module tb_store_buffer;

  localparam int DEPTH = 4;
  localparam int AW    = 32;
  localparam int DW    = 32;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic          cpu_we    = 1'b0;
  logic [AW-1:0] cpu_addr  = '0;
  logic [DW-1:0] cpu_wdata = '0;
  logic [DW-1:0] cpu_rdata;
  logic          stall;
  logic          empty;

  store_buffer_if #(.AW(AW), .DW(DW)) mem_if ();

  store_buffer #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .DW    (DW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .stall     (stall),
    .empty     (empty),
    .mem       (mem_if)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard: pending stores, oldest at index 0, {word addr, data}
  // ---------------------------------------------------------------------------
  logic [AW-2+DW-1:0] exp_q [$];
  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] model_load(input logic [AW-1:0] addr, input logic [DW-1:0] mrd);
    for (int i = exp_q.size() - 1; i >= 0; i--)
      if (exp_q[i][AW-2+DW-1:DW] == addr[AW-1:2]) return exp_q[i][DW-1:0];
    return mrd;
  endfunction

  // Compare every observable output against the reference queue.
  task automatic model_check(input string tag);
    logic exp_req;
    exp_req = (exp_q.size() != 0);
    check({tag, ".empty"}, 64'(empty), 64'(!exp_req));
    check({tag, ".req"},   64'(mem_if.mem_req), 64'(exp_req));
    check({tag, ".stall"}, 64'(stall), 64'(cpu_we && exp_q.size() == DEPTH));
    check({tag, ".raddr"}, 64'(mem_if.mem_raddr), 64'(cpu_addr));
    check({tag, ".rdata"}, 64'(cpu_rdata), 64'(model_load(cpu_addr, mem_if.mem_rdata)));
    if (exp_req) begin
      check({tag, ".waddr"}, 64'(mem_if.mem_waddr), 64'({exp_q[0][AW-2+DW-1:DW], 2'b00}));
      check({tag, ".wdata"}, 64'(mem_if.mem_wdata), 64'(exp_q[0][DW-1:0]));
    end
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks: inputs change at posedge+1, outputs are checked at posedge+3
  // ---------------------------------------------------------------------------
  task automatic set_in(input string tag, input logic we, input logic [AW-1:0] addr,
                        input logic [DW-1:0] wdata, input logic ack, input logic [DW-1:0] rdata);
    cpu_we           = we;
    cpu_addr         = addr;
    cpu_wdata        = wdata;
    mem_if.mem_ack   = ack;
    mem_if.mem_rdata = rdata;
    #2;
    model_check(tag);
  endtask

  task automatic tick();
    logic do_pop, do_push;
    do_pop  = (exp_q.size() != 0) && mem_if.mem_ack;
    do_push = cpu_we && (exp_q.size() < DEPTH);
    @(posedge clk);
    if (do_pop)  void'(exp_q.pop_front());
    if (do_push) exp_q.push_back({cpu_addr[AW-1:2], cpu_wdata});
    #1;
  endtask

  task automatic cycle(input string tag, input logic we, input logic [AW-1:0] addr,
                       input logic [DW-1:0] wdata, input logic ack, input logic [DW-1:0] rdata);
    set_in(tag, we, addr, wdata, ack, rdata);
    tick();
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    mem_if.mem_ack   = 1'b0;
    mem_if.mem_rdata = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Reset then idle
    set_in("idle", 1'b0, 32'h0000_0100, '0, 1'b0, 32'hDEAD_BEEF);
    check("idle_empty", 64'(empty), 64'd1);
    check("idle_req",   64'(mem_if.mem_req), 64'd0);
    check("idle_stall", 64'(stall), 64'd0);
    check("idle_rdata", 64'(cpu_rdata), 64'hDEAD_BEEF);
    tick();

    // Single store, then forwarding with word aliasing
    cycle("st7", 1'b1, 32'h64, 32'd7, 1'b0, '0);
    set_in("ld64", 1'b0, 32'h64, '0, 1'b0, '0);
    check("st7_req",   64'(mem_if.mem_req), 64'd1);
    check("st7_waddr", 64'(mem_if.mem_waddr), 64'h64);
    check("st7_wdata", 64'(mem_if.mem_wdata), 64'd7);
    check("ld64_fwd",  64'(cpu_rdata), 64'd7);
    tick();
    set_in("ld66", 1'b0, 32'h66, '0, 1'b0, '0);
    check("ld66_alias", 64'(cpu_rdata), 64'd7);
    tick();
    cycle("drain7", 1'b0, 32'h64, '0, 1'b1, '0);

    // Two stores to one address: youngest forwards, drain in order
    cycle("st1", 1'b1, 32'h60, 32'd1, 1'b0, 32'h1111_1111);
    cycle("st2", 1'b1, 32'h60, 32'd2, 1'b0, 32'h1111_1111);
    set_in("ld60a", 1'b0, 32'h60, '0, 1'b0, 32'h1111_1111);
    check("ld60_young", 64'(cpu_rdata), 64'd2);
    check("ld60_head",  64'(mem_if.mem_wdata), 64'd1);
    tick();
    cycle("ack1", 1'b0, 32'h60, '0, 1'b1, 32'h1111_1111);
    set_in("ld60b", 1'b0, 32'h60, '0, 1'b0, 32'h1111_1111);
    check("ack1_wdata", 64'(mem_if.mem_wdata), 64'd2);
    check("ack1_fwd",   64'(cpu_rdata), 64'd2);
    tick();
    cycle("ack2", 1'b0, 32'h60, '0, 1'b1, 32'h1111_1111);
    set_in("ld60c", 1'b0, 32'h60, '0, 1'b0, 32'h1111_1111);
    check("ack2_empty", 64'(empty), 64'd1);
    check("ack2_mem",   64'(cpu_rdata), 64'h1111_1111);
    tick();

    // Fill to full, stall, ack during stall, stall releases next cycle
    for (int i = 0; i < DEPTH; i++)
      cycle("fill", 1'b1, 32'h200 + 32'(i * 4), 32'(32'hA0 + i), 1'b0, '0);
    set_in("full_st", 1'b1, 32'h300, 32'hBB, 1'b0, '0);
    check("full_stall", 64'(stall), 64'd1);
    tick();
    set_in("full_ack", 1'b1, 32'h300, 32'hBB, 1'b1, '0);
    check("ack_stall", 64'(stall), 64'd1);
    check("ack_head",  64'(mem_if.mem_wdata), 64'hA0);
    tick();
    set_in("released", 1'b1, 32'h300, 32'hBB, 1'b0, '0);
    check("rel_stall", 64'(stall), 64'd0);
    tick();
    set_in("refull", 1'b1, 32'h304, 32'hCC, 1'b0, '0);
    check("refull_stall", 64'(stall), 64'd1);
    set_in("refull_ld", 1'b0, 32'h300, '0, 1'b0, '0);
    check("refull_fwd", 64'(cpu_rdata), 64'hBB);
    tick();
    for (int i = 0; i < DEPTH; i++)
      cycle("drain_full", 1'b0, 32'h200, '0, 1'b1, 32'h5555_0000);
    set_in("drained", 1'b0, 32'h200, '0, 1'b0, 32'h5555_0000);
    check("drained_empty", 64'(empty), 64'd1);
    tick();

    // Continuous stores with ack always high: never stalls, drains in order
    for (int i = 0; i < 4 * DEPTH * 3; i++) begin
      cycle("stream", 1'b1, 32'h400 + 32'($urandom_range(0, 7) * 4), $urandom, 1'b1, $urandom);
      check("stream_nostall", 64'(stall), 64'd0);
    end
    cycle("stream_end", 1'b0, 32'h400, '0, 1'b1, '0);

    // Randomized mix of stores, loads and acks over a small address pool
    for (int i = 0; i < 400; i++)
      cycle("rand", ($urandom_range(0, 99) < 60), 32'h100 + 32'($urandom_range(0, 7) * 4)
            + 32'($urandom_range(0, 3)), $urandom, ($urandom_range(0, 99) < 45), $urandom);

    // Asynchronous reset with three stores pending
    while (exp_q.size() != 0) cycle("pre_rst", 1'b0, 32'h0, '0, 1'b1, '0);
    for (int i = 0; i < 3; i++)
      cycle("rst_fill", 1'b1, 32'h80 + 32'(i * 4), 32'(i + 9), 1'b0, 32'h7777_7777);
    set_in("pre_async", 1'b0, 32'h80, '0, 1'b0, 32'h7777_7777);
    check("pre_async_req", 64'(mem_if.mem_req), 64'd1);
    reset = 1'b1;
    #1;
    exp_q.delete();
    check("async_req",   64'(mem_if.mem_req), 64'd0);
    check("async_empty", 64'(empty), 64'd1);
    check("async_rdata", 64'(cpu_rdata), 64'h7777_7777);
    @(posedge clk);
    #1 reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_in("post_rst", 1'b0, 32'h80 + 32'(i * 4), '0, 1'b0, 32'h7777_7000 + 32'(i));
      check("post_rst_rdata", 64'(cpu_rdata), 64'(32'h7777_7000 + 32'(i)));
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
